// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution accumulate path.
// Latency: none (declarations only). Backpressure: not applicable.
// Saturation limits are used when CONV_ACC_SAT_EN is defined.
package conv_pkg;

    localparam int ACC_W          = 48;
    localparam int KERNEL_LEN_DEF = 9;

    typedef logic signed [ACC_W-1:0] acc_t;

    localparam acc_t ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam acc_t ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

endpackage

// File: rtl/sat_add48.sv
// Purpose: combinational 48-bit signed add with overflow flag; clamps under CONV_ACC_SAT_EN.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module sat_add48
    import conv_pkg::*;
(
    input  acc_t a,
    input  acc_t b,
    output acc_t sum,
    output logic ovf
);

    acc_t raw;

    assign raw = a + b;
    // Signed overflow: operands agree in sign but the result does not.
    assign ovf = (a[ACC_W-1] == b[ACC_W-1]) && (raw[ACC_W-1] != a[ACC_W-1]);

`ifdef CONV_ACC_SAT_EN
    assign sum = ovf ? (a[ACC_W-1] ? ACC_MIN : ACC_MAX) : raw;
`else
    assign sum = raw;
`endif

endmodule

// File: rtl/conv_window_acc.sv
// Purpose: sums KERNEL_LEN signed products per window into a 48-bit result strobe (CONV_ACC_SAT_EN: saturate + o_sat).
// Latency: o_en pulses 1 cycle after the last product of a window; one product per cycle.
// Backpressure: none; downstream always accepts, o_data is zero whenever o_en is low.
module conv_window_acc
    import conv_pkg::*;
#(
    parameter int KERNEL_LEN = KERNEL_LEN_DEF,
    parameter int PROD_W     = 32
)
(
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_en,
    input  logic signed [PROD_W-1:0] i_data,
    input  logic                     i_clr,
    output logic                     o_en,
    output logic [ACC_W-1:0]         o_data,
`ifdef CONV_ACC_SAT_EN
    output logic                     o_sat,
`endif
    output logic                     o_busy
);

    localparam int CNT_W = (KERNEL_LEN > 1) ? $clog2(KERNEL_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(KERNEL_LEN - 1);

    logic [CNT_W-1:0] cnt;
    acc_t             acc;
    acc_t             prod_ext;
    acc_t             add_base;
    acc_t             add_sum;
    acc_t             next_acc;
    logic             add_ovf;
    logic             last_tap;

    assign prod_ext = acc_t'(i_data);
    // The first tap restarts the window, so the stale sum never needs a clear cycle.
    assign add_base = (cnt == '0) ? '0 : acc;
    assign last_tap = (cnt == CNT_LAST);
    assign o_busy   = (cnt != '0);

    sat_add48 u_add (
        .a   (add_base),
        .b   (prod_ext),
        .sum (add_sum),
        .ovf (add_ovf)
    );

`ifdef CONV_ACC_SAT_EN
    logic sat_win;
    logic next_sat;

    // Once a window has clamped, hold the clamp value until the window completes.
    always_comb begin
        next_acc = add_sum;
        next_sat = add_ovf;
        if ((cnt != '0) && sat_win) begin
            next_acc = acc;
            next_sat = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sat_win <= 1'b0;
            o_sat   <= 1'b0;
        end else begin
            o_sat <= 1'b0;
            if (i_clr) begin
                sat_win <= 1'b0;
            end else if (i_en) begin
                sat_win <= next_sat;
                if (last_tap) begin
                    o_sat <= next_sat;
                end
            end
        end
    end
`else
    logic unused_ovf;

    assign unused_ovf = add_ovf;
    assign next_acc   = add_sum;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt    <= '0;
            acc    <= '0;
            o_en   <= 1'b0;
            o_data <= '0;
        end else begin
            o_en   <= 1'b0;
            o_data <= '0;
            if (i_clr) begin
                cnt <= '0;
                acc <= '0;
            end else if (i_en) begin
                acc <= next_acc;
                if (last_tap) begin
                    cnt    <= '0;
                    o_en   <= 1'b1;
                    o_data <= next_acc;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule
